branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Commit-side counterpart to the fetch-stage next-PC predictor.
- Takes each committed control-flow instruction from the ROB, computes its true next PC and compares it with the PC the predictor chose at fetch.
- On mismatch: stalls commit, asserts a pipeline flush, then hands the correct PC to fetch over a valid/ready redirect handshake.
- Also emits branch-outcome update pulses for a future dynamic predictor table.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_out is held high after a mispredict is detected (legal range 1..15).
- XLEN, 32, PC/address width.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, all state and outputs hold.
- cm_valid  input  1  ROB presents a committing instruction.
- cm_ready  output  1  resolver accepts the commit this cycle.
- cm_opcode  input  7  inst[6:0] of the committing instruction.
- cm_pc  input  XLEN  PC of the instruction.
- cm_pred_pc  input  XLEN  next PC chosen at fetch.
- cm_taken  input  1  resolved branch condition (B_TYPE only).
- cm_target  input  XLEN  resolved target (pc+imm for JAL/B_TYPE, (val1+imm)&~1 for JALR).
- flush_out  output  1  flush all speculative state (RS, LSB, ROB, IQ).
- redir_valid  output  1  redirect PC is valid.
- redir_ready  input  1  fetch accepts the redirect.
- redir_pc  output  XLEN  correct next PC.
- upd_valid  output  1  one-cycle predictor-update pulse.
- upd_pc  output  XLEN  PC of the resolved B_TYPE.
- upd_taken  output  1  its outcome.
- stat_branches  output  32  control-flow commits counted (see optional feature).
- stat_mispred  output  32  mispredicts counted (see optional feature).

Behaviour:
- Reset (rst_in low, async): state=IDLE, flush counter=0, all outputs 0 except cm_ready=0. cm_ready rises in the first IDLE cycle after release.
- Actual next PC:
  - JAL, JALR: cm_target.
  - B_TYPE: cm_taken ? cm_target : cm_pc+4.
  - Any other opcode: cm_pc+4.
  - All adds are mod 2^XLEN (wrap at 0xFFFFFFFC+4 = 0).
- Accept: cm_valid & cm_ready & rdy_in. One commit per cycle; non-mispredicting commits flow back-to-back with no bubbles.
- Mispredict: accepted commit with actual != cm_pred_pc (full XLEN compare).
- States:
  - IDLE: cm_ready=1. On an accepted mispredict, latch the actual PC into redir_pc, load the counter with FLUSH_CYCLES, go to FLUSH at the next edge.
  - FLUSH: cm_ready=0, flush_out=1. Decrement the counter each rdy cycle; when it reaches 0 go to REDIR. flush_out is high for exactly FLUSH_CYCLES rdy cycles, starting the cycle after accept.
  - REDIR: cm_ready=0, flush_out=0, redir_valid=1, redir_pc stable. On redir_ready & rdy_in go to IDLE; redir_valid drops next cycle.
- A commit presented during FLUSH or REDIR is not accepted. The ROB is flushed anyway and any stale cm_valid is ignored.
- upd_valid: registered pulse the cycle after any accepted B_TYPE, predicted or not. Carries upd_pc=cm_pc, upd_taken=cm_taken.
- rdy_in low: no accept, FSM and counter frozen, outputs hold their values.
- Reset asserted mid-FLUSH or mid-REDIR: returns to IDLE immediately; the pending redirect is lost (fetch resets too).

Optional Feature:
- BR_STAT_EN defined:
  - stat_branches increments on every accepted JAL/JALR/B_TYPE.
  - stat_mispred increments on every accepted mispredict.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- BR_STAT_EN undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Const.v (shared): opcode macros `JAL, `JALR, `B_TYPE (existing); add state encodings `BR_IDLE, `BR_FLUSH, `BR_REDIR.
- One natural sub-module: br_actual_pc, purely combinational (opcode, pc, taken, target -> actual next PC).
- FSM, counters and handshake stay in branch_resolver.

Test Plan:
- Correct B_TYPE: pc=0x100, pred=0x140, taken=1, target=0x140 -> no flush; cm_ready stays 1; upd_valid pulse with upd_pc=0x100, upd_taken=1.
- Mispredicted B_TYPE: pc=0x200, pred=0x180, taken=0 -> flush_out high 2 cycles; then redir_valid with redir_pc=0x204; redir_ready held low 3 cycles keeps redir_pc stable; IDLE after ready.
- Mispredicted JALR: pred=0x300, target=0x1000 -> redir_pc=0x1000; cm_valid held during FLUSH/REDIR is not accepted.
- Wrap: non-branch commit at pc=0xFFFFFFFC, pred=0x0 -> no mispredict; pred=0x4 -> redir_pc=0x0.
- rdy_in low for 4 cycles mid-FLUSH -> flush_out stays high throughout; total high rdy cycles is still 2. rst_in low mid-REDIR -> redir_valid=0 immediately.
- BR_STAT_EN defined: 10 commits (6 branches, 2 mispredicted) -> stat_branches=6, stat_mispred=2. Undefined: both read 0.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared opcode and state encodings for the commit-side branch resolver.
// Used by branch_resolver and br_actual_pc.
package branch_resolver_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_B_TYPE = 7'b1100011;

   typedef logic [1:0] br_state_t;

   localparam br_state_t BR_IDLE  = 2'd0;
   localparam br_state_t BR_FLUSH = 2'd1;
   localparam br_state_t BR_REDIR = 2'd2;

   function automatic logic is_ctrl_op(input logic [6:0] op);
      return (op == OP_JAL) || (op == OP_JALR) || (op == OP_B_TYPE);
   endfunction

endpackage

// File: rtl/branch_resolver_actual_pc.sv
// Combinational true-next-PC computation for a committing instruction.
// All additions wrap modulo 2^XLEN.
module br_actual_pc
   import branch_resolver_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [6:0]      opcode,
   input  logic [XLEN-1:0] pc,
   input  logic            taken,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] actual_pc
);

   logic [XLEN-1:0] pc_plus4;

   assign pc_plus4 = pc + XLEN'(4);

   always_comb begin
      actual_pc = pc_plus4;
      case (opcode)
         OP_JAL, OP_JALR: actual_pc = target;
         OP_B_TYPE:       actual_pc = taken ? target : pc_plus4;
         default:         actual_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// Commit-side branch resolver: detects next-PC mispredicts, flushes, then redirects fetch.
// Optional statistics counters are built only when BR_STAT_EN is defined.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int XLEN         = 32
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   input  logic            cm_valid,
   output logic            cm_ready,
   input  logic [6:0]      cm_opcode,
   input  logic [XLEN-1:0] cm_pc,
   input  logic [XLEN-1:0] cm_pred_pc,
   input  logic            cm_taken,
   input  logic [XLEN-1:0] cm_target,
   output logic            flush_out,
   output logic            redir_valid,
   input  logic            redir_ready,
   output logic [XLEN-1:0] redir_pc,
   output logic            upd_valid,
   output logic [XLEN-1:0] upd_pc,
   output logic            upd_taken,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispred
);

   br_state_t       state_r, state_nxt;
   logic [3:0]      cnt_r;
   logic            ready_r;
   logic [XLEN-1:0] actual_pc_p0;
   logic            accept_p0, mispred_p0, is_b_p0;
   logic [XLEN-1:0] redir_pc_p1;
   logic            upd_vld_p1, upd_taken_p1;
   logic [XLEN-1:0] upd_pc_p1;

   br_actual_pc #(.XLEN(XLEN)) u_actual (
      .opcode    (cm_opcode),
      .pc        (cm_pc),
      .taken     (cm_taken),
      .target    (cm_target),
      .actual_pc (actual_pc_p0)
   );

   assign accept_p0  = cm_valid & ready_r & rdy_in;
   assign mispred_p0 = accept_p0 & (actual_pc_p0 != cm_pred_pc);
   assign is_b_p0    = (cm_opcode == OP_B_TYPE);

   always_comb begin
      state_nxt = state_r;
      case (state_r)
         BR_IDLE:  if (mispred_p0) state_nxt = BR_FLUSH;
         BR_FLUSH: if (cnt_r <= 4'd1) state_nxt = BR_REDIR;
         BR_REDIR: if (redir_ready) state_nxt = BR_IDLE;
         default:  state_nxt = BR_IDLE;
      endcase
   end

   // p0 -> p1: FSM, flush counter, redirect PC and predictor-update record
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r      <= BR_IDLE;
         cnt_r        <= 4'd0;
         ready_r      <= 1'b0;
         redir_pc_p1  <= '0;
         upd_vld_p1   <= 1'b0;
         upd_pc_p1    <= '0;
         upd_taken_p1 <= 1'b0;
      end else if (rdy_in) begin
         state_r    <= state_nxt;
         ready_r    <= (state_nxt == BR_IDLE);
         upd_vld_p1 <= accept_p0 & is_b_p0;
         if (mispred_p0) begin
            cnt_r       <= 4'(FLUSH_CYCLES);
            redir_pc_p1 <= actual_pc_p0;
         end else if (state_r == BR_FLUSH && cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
         end
         if (accept_p0 && is_b_p0) begin
            upd_pc_p1    <= cm_pc;
            upd_taken_p1 <= cm_taken;
         end
      end
   end

   assign cm_ready    = ready_r;
   assign flush_out   = (state_r == BR_FLUSH);
   assign redir_valid = (state_r == BR_REDIR);
   assign redir_pc    = redir_pc_p1;
   assign upd_valid   = upd_vld_p1;
   assign upd_pc      = upd_pc_p1;
   assign upd_taken   = upd_taken_p1;

`ifdef BR_STAT_EN
   logic [31:0] stat_br_r, stat_mp_r;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // p0 -> p1: saturating event counters
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stat_br_r <= 32'd0;
         stat_mp_r <= 32'd0;
      end else begin
         if (accept_p0 && is_ctrl_op(cm_opcode)) stat_br_r <= sat_inc(stat_br_r);
         if (mispred_p0) stat_mp_r <= sat_inc(stat_mp_r);
      end
   end

   assign stat_branches = stat_br_r;
   assign stat_mispred  = stat_mp_r;
`else
   assign stat_branches = 32'd0;
   assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: vector table, corner sequences, random vs reference model.
// Statistics checks follow BR_STAT_EN.
module tb_branch_resolver;
   import branch_resolver_pkg::*;

   localparam int FC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
   logic        cm_valid = 1'b0;
   logic        cm_ready;
   logic [6:0]  cm_opcode = 7'd0;
   logic [31:0] cm_pc = '0, cm_pred_pc = '0, cm_target = '0;
   logic        cm_taken = 1'b0;
   logic        flush_out, redir_valid, upd_valid, upd_taken;
   logic        redir_ready = 1'b0;
   logic [31:0] redir_pc, upd_pc, stat_branches, stat_mispred;

   int pass_cnt = 0, total_cnt = 0;
   int m_branches = 0, m_mispred = 0;

   always #5 clk = ~clk;

   branch_resolver #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
      .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_opcode(cm_opcode),
      .cm_pc(cm_pc), .cm_pred_pc(cm_pred_pc), .cm_taken(cm_taken), .cm_target(cm_target),
      .flush_out(flush_out), .redir_valid(redir_valid), .redir_ready(redir_ready),
      .redir_pc(redir_pc), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .stat_branches(stat_branches), .stat_mispred(stat_mispred)
   );

   typedef struct {
      logic [6:0]  op;
      logic [31:0] pc;
      logic [31:0] pred;
      logic [31:0] tgt;
      logic        taken;
      logic        exp_mis;
      logic [31:0] exp_pc;
      int          hold;
      logic        stale;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   // Next PC straight from the ISA rules.
   function automatic logic [31:0] ref_next(input logic [6:0] op, input logic [31:0] pc,
                                            input logic taken, input logic [31:0] tgt);
      logic [32:0] seq;
      seq = {1'b0, pc} + 33'd4;
      if (op == OP_JAL || op == OP_JALR) return tgt;
      if (op == OP_B_TYPE && taken) return tgt;
      return seq[31:0];
   endfunction

   task automatic check_stats(input string tag);
`ifdef BR_STAT_EN
      chk({tag, "_stat_branches"}, stat_branches, 32'(m_branches));
      chk({tag, "_stat_mispred"}, stat_mispred, 32'(m_mispred));
`else
      chk({tag, "_stat_branches_off"}, stat_branches, 32'd0);
      chk({tag, "_stat_mispred_off"}, stat_mispred, 32'd0);
`endif
   endtask

   task automatic do_commit(input vec_t v);
      int n;
      @(negedge clk);
      cm_valid = 1'b1; cm_opcode = v.op; cm_pc = v.pc; cm_pred_pc = v.pred;
      cm_target = v.tgt; cm_taken = v.taken;
      chk("cm_ready_idle", 32'(cm_ready), 32'd1);
      if (is_ctrl_op(v.op)) m_branches++;
      if (v.exp_mis) m_mispred++;
      @(negedge clk);
      if (v.stale && v.exp_mis) begin
         cm_opcode = OP_B_TYPE;
         cm_pc = v.pc + 32'h40;
      end else cm_valid = 1'b0;
      chk("upd_valid", 32'(upd_valid), 32'(v.op == OP_B_TYPE));
      if (v.op == OP_B_TYPE) begin
         chk("upd_pc", upd_pc, v.pc);
         chk("upd_taken", 32'(upd_taken), 32'(v.taken));
      end
      chk("flush_start", 32'(flush_out), 32'(v.exp_mis));
      if (!v.exp_mis) begin
         chk("cm_ready_flow", 32'(cm_ready), 32'd1);
         cm_valid = 1'b0;
         return;
      end
      n = 0;
      while (flush_out === 1'b1 && n < 40) begin
         n++;
         if (v.stale) chk("stale_not_ready", 32'(cm_ready), 32'd0);
         @(negedge clk);
      end
      chk("flush_len", 32'(n), 32'(FC));
      chk("redir_valid", 32'(redir_valid), 32'd1);
      chk("redir_pc", redir_pc, v.exp_pc);
      if (v.stale) chk("stale_no_upd", 32'(upd_valid), 32'd0);
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk("redir_hold_valid", 32'(redir_valid), 32'd1);
         chk("redir_hold_pc", redir_pc, v.exp_pc);
         chk("redir_hold_ready", 32'(cm_ready), 32'd0);
      end
      cm_valid = 1'b0;
      redir_ready = 1'b1;
      @(negedge clk);
      redir_ready = 1'b0;
      chk("redir_drop", 32'(redir_valid), 32'd0);
      chk("cm_ready_back", 32'(cm_ready), 32'd1);
   endtask

   initial begin
      vec_t v;
      int n;
      logic [6:0] ops[6];
      logic [31:0] apc;
      int seq_idx[10];

      ops[0] = OP_JAL; ops[1] = OP_JALR; ops[2] = OP_B_TYPE;
      ops[3] = 7'h13;  ops[4] = 7'h33;   ops[5] = 7'h03;
      vecs[0] = '{OP_B_TYPE, 32'h100, 32'h140, 32'h140, 1'b1, 1'b0, 32'h140, 0, 1'b0};
      vecs[1] = '{OP_B_TYPE, 32'h200, 32'h180, 32'h180, 1'b0, 1'b1, 32'h204, 3, 1'b0};
      vecs[2] = '{OP_JALR, 32'h050, 32'h300, 32'h1000, 1'b0, 1'b1, 32'h1000, 1, 1'b1};
      vecs[3] = '{7'h13, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 0, 1'b0};
      vecs[4] = '{7'h13, 32'hFFFFFFFC, 32'h4, 32'h0, 1'b0, 1'b1, 32'h0, 0, 1'b0};
      vecs[5] = '{OP_JAL, 32'h400, 32'h480, 32'h480, 1'b0, 1'b0, 32'h480, 0, 1'b0};
      vecs[6] = '{OP_B_TYPE, 32'h500, 32'h504, 32'h600, 1'b0, 1'b0, 32'h504, 0, 1'b0};
      vecs[7] = '{OP_JAL, 32'h600, 32'h604, 32'h800, 1'b0, 1'b1, 32'h800, 2, 1'b0};
      vecs[8] = '{OP_B_TYPE, 32'hFFFFFFFC, 32'h0, 32'h100, 1'b0, 1'b0, 32'h0, 0, 1'b0};
      vecs[9] = '{7'h33, 32'h700, 32'h704, 32'h900, 1'b1, 1'b0, 32'h704, 0, 1'b0};

      // Reset values
      #1;
      chk("rst_cm_ready", 32'(cm_ready), 32'd0);
      chk("rst_flush", 32'(flush_out), 32'd0);
      chk("rst_redir_valid", 32'(redir_valid), 32'd0);
      chk("rst_upd_valid", 32'(upd_valid), 32'd0);
      chk("rst_redir_pc", redir_pc, 32'd0);
      check_stats("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("release_ready_low", 32'(cm_ready), 32'd0);
      @(negedge clk);
      chk("first_idle_ready", 32'(cm_ready), 32'd1);

      for (int i = 0; i < 10; i++) do_commit(vecs[i]);
      check_stats("table");

      // Back-to-back correct commits with no bubbles
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         cm_valid = 1'b1; cm_opcode = OP_B_TYPE; cm_pc = 32'h1000 + 32'(i * 16);
         cm_taken = i[0]; cm_target = 32'h2000 + 32'(i * 16);
         cm_pred_pc = ref_next(cm_opcode, cm_pc, cm_taken, cm_target);
         m_branches++;
         chk("b2b_ready", 32'(cm_ready), 32'd1);
         @(negedge clk);
         chk("b2b_upd_valid", 32'(upd_valid), 32'd1);
         chk("b2b_upd_pc", upd_pc, 32'h1000 + 32'(i * 16));
         chk("b2b_no_flush", 32'(flush_out), 32'd0);
      end
      cm_valid = 1'b0;

      // rdy_in low mid-FLUSH
      @(negedge clk);
      cm_valid = 1'b1; cm_opcode = OP_B_TYPE; cm_pc = 32'h800; cm_taken = 1'b1;
      cm_target = 32'h900; cm_pred_pc = 32'h804;
      m_branches++; m_mispred++;
      @(negedge clk);
      cm_valid = 1'b0;
      chk("rdy_flush_start", 32'(flush_out), 32'd1);
      rdy = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("rdy_low_flush", 32'(flush_out), 32'd1);
         chk("rdy_low_no_redir", 32'(redir_valid), 32'd0);
      end
      rdy = 1'b1;
      n = 0;
      while (flush_out === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("rdy_flush_rdy_cycles", 32'(n), 32'(FC));
      chk("rdy_redir_pc", redir_pc, 32'h900);
      redir_ready = 1'b1;
      @(negedge clk);
      redir_ready = 1'b0;
      chk("rdy_redir_drop", 32'(redir_valid), 32'd0);

      // Randomised commits against the reference model
      for (int i = 0; i < 40; i++) begin
         v.op = ops[$urandom_range(0, 5)];
         v.pc = {$urandom(), 2'b00} >> 2 << 2;
         v.tgt = {$urandom()} & 32'hFFFF_FFFC;
         v.taken = 1'($urandom_range(0, 1));
         apc = ref_next(v.op, v.pc, v.taken, v.tgt);
         v.pred = ($urandom_range(0, 1) == 1) ? apc : ({$urandom()} & 32'hFFFF_FFFC);
         v.exp_mis = (v.pred != apc);
         v.exp_pc = apc;
         v.hold = $urandom_range(0, 2);
         v.stale = 1'($urandom_range(0, 1));
         do_commit(v);
      end
      check_stats("random");

      // Reset asserted mid-REDIR drops the redirect at once
      v = vecs[1];
      v.hold = 0;
      @(negedge clk);
      cm_valid = 1'b1; cm_opcode = v.op; cm_pc = v.pc; cm_pred_pc = v.pred;
      cm_target = v.tgt; cm_taken = v.taken;
      @(negedge clk);
      cm_valid = 1'b0;
      n = 0;
      while (redir_valid !== 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("pre_rst_redir", 32'(redir_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_redir_valid", 32'(redir_valid), 32'd0);
      chk("rst_mid_flush", 32'(flush_out), 32'd0);
      chk("rst_mid_ready", 32'(cm_ready), 32'd0);
      m_branches = 0; m_mispred = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(cm_ready), 32'd1);
      check_stats("post_rst");

      // Ten commits: six control-flow, two mispredicted
      seq_idx = '{0, 1, 3, 5, 6, 9, 0, 7, 3, 9};
      for (int i = 0; i < 10; i++) do_commit(vecs[seq_idx[i]]);
`ifdef BR_STAT_EN
      chk("stat10_branches", stat_branches, 32'd6);
      chk("stat10_mispred", stat_mispred, 32'd2);
`else
      chk("stat10_branches_off", stat_branches, 32'd0);
      chk("stat10_mispred_off", stat_mispred, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
